// File: rtl/cpu_defs.sv
// Shared CPU definitions: transfer-kind and sequencer state encodings plus
// the default reset and exception-vector fetch addresses.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_4180;

  // Control-transfer kind presented by decode
  typedef enum logic [1:0] {
    BR_REL     = 2'd0,  // PC-relative conditional branch
    BR_JUMP    = 2'd1,  // j / jal (region jump)
    BR_JR      = 2'd2,  // jump to register value
    BR_ILLEGAL = 2'd3   // never taken
  } br_kind_e;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request issued, normal operation
    ST_WAIT  = 2'd1,  // request outstanding, memory has not answered
    ST_KILL  = 2'd2,  // outstanding request must be discarded, redirect pending
    ST_HOLD  = 2'd3   // decode stalled, no request
  } seq_state_e;

endpackage

// File: rtl/target_calc.sv
// Control-transfer target calculation and taken decision.
// Ports:
//   br_valid_i  - decode presents a resolved transfer
//   br_kind_i   - transfer kind (br_kind_e)
//   br_taken_i  - condition result, only used by PC-relative branches
//   br_pc4_i    - PC+4 of the transfer instruction
//   br_imm_i    - offset, instr_index or register value depending on kind
//   target_o_c  - computed destination address (combinational)
//   taken_o_c   - transfer redirects fetch (combinational)
module target_calc
  import cpu_defs::*;
(
  input  logic            br_valid_i,
  input  logic [1:0]      br_kind_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_pc4_i,
  input  logic [XLEN-1:0] br_imm_i,
  output logic [XLEN-1:0] target_o_c,
  output logic            taken_o_c
);

  // Decode target per kind; illegal kind is never taken
  always_comb begin
    target_o_c = br_imm_i;
    taken_o_c  = 1'b0;
    case (br_kind_e'(br_kind_i))
      BR_REL: begin
        target_o_c = br_pc4_i + {br_imm_i[XLEN-3:0], 2'b00};
        taken_o_c  = br_valid_i & br_taken_i;
      end
      BR_JUMP: begin
        target_o_c = {br_pc4_i[XLEN-1:XLEN-4], br_imm_i[XLEN-7:0], 2'b00};
        taken_o_c  = br_valid_i;
      end
      BR_JR: begin
        target_o_c = br_imm_i;
        taken_o_c  = br_valid_i;
      end
      default: begin
        target_o_c = br_imm_i;
        taken_o_c  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: issues fetch requests, advances the PC,
// applies exception / eret / branch redirects and decode stalls, and discards
// a fetch that was overtaken by a redirect while still outstanding.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   stall               - decode hazard hold
//   br_valid/kind/taken - resolved control transfer from decode
//   br_pc4, br_imm      - operands for the transfer target
//   exc_req, eret_req   - exception entry / return requests
//   epc                 - eret return address
//   imem_req, imem_ack  - instruction memory handshake
//   pc                  - current fetch address
//   instr_valid         - returned instruction is consumed (combinational)
//   if_flush            - kill IF/ID contents (combinational)
module pc_sequencer
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [1:0]  br_kind,
  input  logic        br_taken,
  input  logic [31:0] br_pc4,
  input  logic [31:0] br_imm,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        if_flush
);

  seq_state_e        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              req_q, req_d;

  logic [XLEN-1:0]   br_target;
  logic              br_take;
  logic              redirect;
  logic [XLEN-1:0]   redir_target;

  target_calc u_target_calc (
    .br_valid_i (br_valid),
    .br_kind_i  (br_kind),
    .br_taken_i (br_taken),
    .br_pc4_i   (br_pc4),
    .br_imm_i   (br_imm),
    .target_o_c (br_target),
    .taken_o_c  (br_take)
  );

  // Redirect priority: exception > eret > taken transfer
  assign redirect     = exc_req | eret_req | br_take;
  assign redir_target = exc_req  ? EXC_VEC :
                        eret_req ? epc     : br_target;

  // Next state, next PC and handshake outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_pc_d  = redir_pc_q;
    instr_valid = 1'b0;
    // Exception/eret are accepted in every state; reset gating keeps it low in reset
    if_flush    = reset & (exc_req | eret_req);

    case (state_q)
      ST_FETCH, ST_WAIT: begin
        if (!req_q) begin
          // First cycle after reset: no request out yet, redirect may retarget it
          if (redirect) pc_d = redir_target;
          state_d = ST_FETCH;
        end else if (imem_ack) begin
          instr_valid = 1'b1;
          state_d     = ST_FETCH;
          if (redirect)   pc_d    = redir_target;
          else if (stall) state_d = ST_HOLD;
          else            pc_d    = pc_q + 32'd4;
        end else if (redirect) begin
          redir_pc_d = redir_target;
          state_d    = ST_KILL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_KILL: begin
        // The answering fetch is stale; a newer redirect supersedes the latched one
        if (imem_ack) begin
          pc_d    = redirect ? redir_target : redir_pc_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          redir_pc_d = redir_target;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redir_target;
          state_d = ST_FETCH;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    req_d = (state_d != ST_HOLD);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      req_q      <= req_d;
    end
  end

  assign pc       = pc_q;
  assign imem_req = req_q;

endmodule
